// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Drives the head of a configuration (ccff) shift chain from a word-wide bitstream and
//   repacks the bits displaced out of the chain tail into readback words.
//
// Ports
//   prog_clk       configuration clock, also clocks the driven chain
//   pReset         asynchronous active-high reset
//   start          one-cycle pulse that begins a load; only honoured while idle
//   bs_data        bitstream word, bit 0 shifted first
//   bs_valid       bs_data valid
//   bs_ready       loader accepts bs_data this cycle
//   ccff_head      serial bit into the chain
//   config_enable  chain shift enable, high only while a real bit is presented
//   ccff_tail      serial bit out of the chain
//   rb_data        readback word of displaced chain bits, bit 0 is the first bit out
//   rb_valid       one-cycle strobe qualifying rb_data (no backpressure)
//   busy           high whenever not idle
//   done           one-cycle pulse once CHAIN_LEN bits have been shifted
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 44,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BitCntW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WordCntW = $clog2(WORD_W + 1);

  localparam logic [BitCntW-1:0]  LastBit     = BitCntW'(CHAIN_LEN - 1);
  localparam logic [WordCntW-1:0] LastWordBit = WordCntW'(WORD_W - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WordCntW-1:0] word_bit_q, word_bit_d;
  logic [WordCntW-1:0] rb_cnt_q, rb_cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   rb_shift_q, rb_shift_d;
  logic [WORD_W-1:0]   rb_data_q, rb_data_d;
  logic                rb_valid_q, rb_valid_d;

  // Readback word with this cycle's (pre-shift) tail bit merged in at position rb_cnt.
  logic [WORD_W-1:0]   rb_word;
  logic                last_bit;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_bit_d    = word_bit_q;
    rb_cnt_d      = rb_cnt_q;
    shift_d       = shift_q;
    rb_shift_d    = rb_shift_q;
    rb_data_d     = rb_data_q;
    rb_valid_d    = 1'b0;
    bs_ready      = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    done          = 1'b0;
    busy          = (state_q != StIdle);
    rb_word       = rb_shift_q | (WORD_W'(ccff_tail) << rb_cnt_q);
    last_bit      = (bit_cnt_q == LastBit);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          bit_cnt_d  = '0;
          rb_cnt_d   = '0;
          rb_shift_d = '0;
        end
      end
      StLoad: begin
        bs_ready = 1'b1;
        if (bs_valid) begin
          shift_d    = bs_data;
          word_bit_d = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        config_enable = 1'b1;
        ccff_head     = shift_q[0];
        shift_d       = shift_q >> 1;
        bit_cnt_d     = bit_cnt_q + 1'b1;
        word_bit_d    = word_bit_q + 1'b1;
        // A full readback word and end-of-chain share one emission; a partial final
        // word goes out with zero high bits because rb_shift was cleared.
        if (rb_cnt_q == LastWordBit || last_bit) begin
          rb_data_d  = rb_word;
          rb_valid_d = 1'b1;
          rb_cnt_d   = '0;
          rb_shift_d = '0;
        end else begin
          rb_shift_d = rb_word;
          rb_cnt_d   = rb_cnt_q + 1'b1;
        end
        // Unused high bits of a partial final word are simply never shifted.
        if (last_bit) begin
          state_d = StDone;
        end else if (word_bit_q == LastWordBit) begin
          state_d = StLoad;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      word_bit_q <= '0;
      rb_cnt_q   <= '0;
      shift_q    <= '0;
      rb_shift_q <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_bit_q <= word_bit_d;
      rb_cnt_q   <= rb_cnt_d;
      shift_q    <= shift_d;
      rb_shift_q <= rb_shift_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
//   Bench for ccff_chain_loader with a behavioural 44-flop chain on ccff_head/ccff_tail.
//   Expected chain contents and readback words come from a bit-stream model: stream bit k
//   ends at chain[CL-1-k], and readback bit k is the old chain[CL-1-k].
module tb_ccff_chain_loader;

  localparam int CL = 44;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;
  localparam int LOAD_LAT = NW + CL;

  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b1;
  logic          start    = 1'b0;
  logic [WW-1:0] bs_data  = '0;
  logic          bs_valid = 1'b0;
  logic          bs_ready;
  logic          ccff_head;
  logic          config_enable;
  logic          ccff_tail;
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CL-1:0] chain;
  logic [CL-1:0] preload_val = '0;
  logic          preload_req = 1'b0;
  int            cyc      = 0;
  int            en_cnt   = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  logic [WW-1:0] rb_q[$];

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(
    .CHAIN_LEN(CL),
    .WORD_W   (WW)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .bs_data      (bs_data),
    .bs_valid     (bs_valid),
    .bs_ready     (bs_ready),
    .ccff_head    (ccff_head),
    .config_enable(config_enable),
    .ccff_tail    (ccff_tail),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .done         (done)
  );

  // Behavioural chain: head enters bit 0, tail leaves from the top bit.
  assign ccff_tail = chain[CL-1];

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (preload_req) chain <= preload_val;
    else if (config_enable) chain <= {chain[CL-2:0], ccff_head};
  end

  always @(negedge prog_clk) begin
    if (config_enable) en_cnt <= en_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rb_valid) rb_q.push_back(rb_data);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge prog_clk);
    #1;
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  task automatic run_load(input logic [NW*WW-1:0] words, input int stall, input bit poke,
                          output logic [NW*WW-1:0] rb_got);
    logic [CL-1:0]    old_chain;
    logic [CL-1:0]    exp_chain;
    logic [CL-1:0]    snap;
    logic [NW*WW-1:0] exp_rb;
    int rb_base, en_base, done_base, c_load, n, en0;
    bit to;
    old_chain = chain;
    rb_base   = rb_q.size();
    en_base   = en_cnt;
    done_base = done_cnt;
    exp_rb    = '0;
    exp_chain = '0;
    for (int k = 0; k < CL; k++) begin
      exp_chain[CL-1-k] = words[k];
      exp_rb[k]         = old_chain[CL-1-k];
    end

    start = 1'b1;
    tick();
    start  = 1'b0;
    c_load = cyc;
    to     = 1'b0;
    for (int w = 0; w < NW; w++) begin
      n = 0;
      while (!bs_ready && n < 200) begin
        tick();
        n++;
      end
      if (!bs_ready) to = 1'b1;
      if (stall > 0) begin
        snap = chain;
        en0  = en_cnt;
        repeat (stall) tick();
        check("stall_enable", 64'(en_cnt - en0), 64'(0));
        check("stall_chain", 64'(chain), 64'(snap));
      end
      bs_data  = words[w*WW +: WW];
      bs_valid = 1'b1;
      tick();
      bs_valid = 1'b0;
      if (poke && w == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    if (to) check("bs_ready_timeout", 64'(0), 64'(1));

    n = 0;
    while (done_cnt == done_base && n < 200) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done_cnt != done_base), 64'(1));
    repeat (3) tick();
    check("done_once", 64'(done_cnt - done_base), 64'(1));
    if (stall == 0) check("done_latency", 64'(done_cyc - c_load), 64'(LOAD_LAT));
    check("enable_cycles", 64'(en_cnt - en_base), 64'(CL));
    check("chain", 64'(chain), 64'(exp_chain));
    check("rb_count", 64'(rb_q.size() - rb_base), 64'(NW));
    rb_got = '0;
    for (int i = 0; i < NW; i++) begin
      if (rb_base + i < rb_q.size()) rb_got[i*WW +: WW] = rb_q[rb_base + i];
    end
    check("rb_words", 64'(rb_got), 64'(exp_rb));
    check("back_idle", 64'({busy, bs_ready, config_enable}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW*WW-1:0] fixed_words, pat, rb_got, rnd;
    logic [CL-1:0]    ref_chain;
    int en0, n;
    fixed_words = {8'h0F, 8'h81, 8'h00, 8'hFF, 8'h3C, 8'hA5};

    // Reset and idle behaviour.
    repeat (3) tick();
    pReset = 1'b0;
    tick();
    @(posedge prog_clk);
    #2 pReset = 1'b1;
    #1;
    check("reset_outputs",
          64'({bs_ready, ccff_head, config_enable, rb_valid, busy, done}), 64'(0));
    check("reset_rb_data", 64'(rb_data), 64'(0));
    tick();
    pReset = 1'b0;
    en0 = en_cnt;
    repeat (100) tick();
    check("idle_enable", 64'(en_cnt - en0), 64'(0));
    check("idle_outputs", 64'({bs_ready, busy, done, rb_valid}), 64'(0));

    // Full load of the reference words into an all-ones chain.
    preload('1);
    run_load(fixed_words, 0, 1'b0, rb_got);
    check("rb_all_ones", 64'(rb_got), 64'(48'h0F_FF_FF_FF_FF_FF));
    ref_chain = chain;

    // Same load with source stalls before every word.
    preload('1);
    run_load(fixed_words, 3, 1'b0, rb_got);
    check("stall_final_chain", 64'(chain), 64'(ref_chain));

    // Round trip: a zero load reads back the previous pattern.
    pat = NW*WW'({$urandom(), $urandom()});
    run_load(pat, 0, 1'b0, rb_got);
    run_load('0, 0, 1'b0, rb_got);
    check("round_trip", 64'(rb_got), 64'(pat & 48'h0F_FF_FF_FF_FF_FF));

    // Abort after 20 shifted bits.
    en0      = en_cnt;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    bs_data  = WW'($urandom());
    bs_valid = 1'b1;
    n = 0;
    while (en_cnt - en0 < 20 && n < 200) begin
      tick();
      n++;
    end
    check("abort_reached_20", 64'(en_cnt - en0), 64'(20));
    check("abort_pre_enable", 64'(config_enable), 64'(1));
    pReset = 1'b1;
    #1;
    check("abort_enable_drop", 64'(config_enable), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    tick();
    pReset   = 1'b0;
    bs_valid = 1'b0;
    tick();
    rnd = NW*WW'({$urandom(), $urandom()});
    run_load(rnd, int'($urandom_range(0, 3)), 1'b0, rb_got);

    // Start pulsed in the middle of shifting is ignored.
    rnd = NW*WW'({$urandom(), $urandom()});
    run_load(rnd, 0, 1'b1, rb_got);

    // Randomized loads.
    for (int t = 0; t < 4; t++) begin
      preload(CL'({$urandom(), $urandom()}));
      rnd = NW*WW'({$urandom(), $urandom()});
      run_load(rnd, int'($urandom_range(0, 3)), 1'b0, rb_got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
